// File: rtl/tlul_rot_host_adapter_if.sv
// Core-side register-access interface of the TL-UL host adapter.
//   req/we/addr/wdata/be : access request, held by the requester until gnt
//   gnt                  : request accepted this cycle
//   rvalid/rdata/err     : one-cycle response pulse; rdata is 0 for writes and errors
//   busy                 : at least one request in flight
// The master modport is the requester (CSR shim or sequencer), slave is the adapter.
interface tlul_rot_host_adapter_if;
  logic        req;
  logic        gnt;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;
  logic        busy;

  modport master (
    output req, we, addr, wdata, be,
    input  gnt, rvalid, rdata, err, busy
  );

  modport slave (
    input  req, we, addr, wdata, be,
    output gnt, rvalid, rdata, err, busy
  );
endinterface

// File: rtl/tlul_rot_host_adapter.sv
// TL-UL types shared by the adapter and its environment.
package tlul_pkg;
  localparam logic [2:0] PutFullData    = 3'h0;
  localparam logic [2:0] PutPartialData = 3'h1;
  localparam logic [2:0] Get            = 3'h4;
  localparam logic [2:0] AccessAck      = 3'h0;
  localparam logic [2:0] AccessAckData  = 3'h1;

  typedef struct packed {
    logic        a_valid;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic        d_valid;
    logic [2:0]  d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic        d_sink;
    logic [31:0] d_data;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;
endpackage

// TL-UL host adapter in front of the TLROT device port.
// Turns req/gnt register accesses into single-beat A-channel Get/PutFullData/PutPartialData
// and returns D-channel acks as rvalid/rdata/err pulses. Tracks in-flight sources with a
// credit limit, fails the oldest request on a response timeout and rejects misaligned
// addresses locally without touching the bus.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   core          : requester-side interface (slave modport)
//   tl_o, tl_i    : TL-UL host-to-device / device-to-host
module tlul_rot_host_adapter
  import tlul_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned TIMEOUT_CYCLES  = 1024,
  parameter logic [31:0] BASE_ADDR       = 32'h3b00_0000
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  tlul_rot_host_adapter_if.slave  core,
  output tl_h2d_t                 tl_o,
  input  tl_d2h_t                 tl_i
);

  localparam int unsigned IdxW    = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned TmoW    = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [2:0]  MaxCnt  = 3'(MAX_OUTSTANDING);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYCLES - 1);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(MAX_OUTSTANDING - 1);
  localparam logic [IdxW:0]   NumSrc  = (IdxW + 1)'(MAX_OUTSTANDING);

  logic [2:0]                 count_q, count_d;
  logic [MAX_OUTSTANDING-1:0] inflight_q, inflight_d;
  logic [MAX_OUTSTANDING-1:0] is_write_q, is_write_d;
  logic [TmoW-1:0]            tmo_q, tmo_d;
  logic [IdxW-1:0]            next_src_q, next_src_d;
  logic                       rvalid_q, rvalid_d;
  logic                       err_q, err_d;
  logic [31:0]                rdata_q, rdata_d;
  logic                       busy_q, busy_d;

  logic            misaligned;
  logic            a_valid;
  logic            a_fire;
  logic            local_gnt;
  logic            d_src_ok;
  logic [IdxW-1:0] d_idx;
  logic            d_retire;
  logic            d_op_bad;
  logic            d_err;
  logic            tmo_fire;
  logic            retire;
  logic            oldest_found;
  logic [IdxW-1:0] oldest_idx;
  logic [IdxW:0]   probe;

  // Fields that carry no information for this host.
  logic unused_tl;
  assign unused_tl = ^{tl_i.d_param, tl_i.d_size, tl_i.d_sink, BASE_ADDR};

  assign misaligned = core.addr[1:0] != 2'b00;

  assign d_src_ok = tl_i.d_source < 8'(MAX_OUTSTANDING);
  assign d_idx    = tl_i.d_source[IdxW-1:0];
  // Beats for sources not in flight (late after timeout, stray, or after reset) are dropped.
  assign d_retire = tl_i.d_valid & d_src_ok & inflight_q[d_idx];
  assign d_op_bad = is_write_q[d_idx] ? (tl_i.d_opcode != AccessAck)
                                      : (tl_i.d_opcode != AccessAckData);
  assign d_err    = tl_i.d_error | d_op_bad;

  // Sources are handed out cyclically from next_src, so scanning upward from next_src
  // visits in-flight sources in issue order; the first hit is the oldest.
  always_comb begin
    oldest_found = 1'b0;
    oldest_idx   = '0;
    probe        = '0;
    for (int unsigned k = 0; k < MAX_OUTSTANDING; k++) begin
      probe = {1'b0, next_src_q} + (IdxW + 1)'(k);
      if (probe >= NumSrc) probe = probe - NumSrc;
      if (!oldest_found && inflight_q[probe[IdxW-1:0]]) begin
        oldest_found = 1'b1;
        oldest_idx   = probe[IdxW-1:0];
      end
    end
  end

  // Any D beat, even a dropped one, counts as bus activity and holds off the timeout.
  assign tmo_fire = (count_q != 3'd0) & ~tl_i.d_valid & (tmo_q == TmoLast) & oldest_found;
  assign retire   = d_retire | tmo_fire;

  assign a_valid   = core.req & ~misaligned & (count_q < MaxCnt) & ~inflight_q[next_src_q];
  assign a_fire    = a_valid & tl_i.a_ready;
  // The response register is shared, so a local error waits while a bus retire uses it.
  assign local_gnt = core.req & misaligned & ~retire;

  assign core.gnt    = a_fire | local_gnt;
  assign core.rvalid = rvalid_q;
  assign core.rdata  = rdata_q;
  assign core.err    = err_q;
  assign core.busy   = busy_q;

  always_comb begin
    tl_o           = '0;
    tl_o.a_valid   = a_valid;
    tl_o.a_param   = 3'd0;
    tl_o.a_size    = 2'd2;
    tl_o.a_source  = 8'(next_src_q);
    tl_o.a_address = core.addr;
    tl_o.a_data    = core.wdata;
    tl_o.a_mask    = core.we ? core.be : 4'hF;
    tl_o.d_ready   = 1'b1;
    if (!core.we) begin
      tl_o.a_opcode = Get;
    end else if (core.be == 4'hF) begin
      tl_o.a_opcode = PutFullData;
    end else begin
      tl_o.a_opcode = PutPartialData;
    end
  end

  always_comb begin
    inflight_d = inflight_q;
    is_write_d = is_write_q;
    next_src_d = next_src_q;
    if (a_fire) begin
      inflight_d[next_src_q] = 1'b1;
      is_write_d[next_src_q] = core.we;
      next_src_d             = (next_src_q == LastIdx) ? '0 : next_src_q + 1'b1;
    end
    // The issuing source is never in flight, so these never collide with the set above.
    if (d_retire) begin
      inflight_d[d_idx] = 1'b0;
    end else if (tmo_fire) begin
      inflight_d[oldest_idx] = 1'b0;
    end

    count_d = count_q + {2'b00, a_fire} - {2'b00, retire};

    if (tl_i.d_valid || (count_q == 3'd0) || tmo_fire) begin
      tmo_d = '0;
    end else begin
      tmo_d = tmo_q + 1'b1;
    end

    rvalid_d = retire | local_gnt;
    err_d    = 1'b0;
    rdata_d  = '0;
    if (d_retire) begin
      err_d = d_err;
      if (!is_write_q[d_idx] && !d_err) rdata_d = tl_i.d_data;
    end else if (tmo_fire || local_gnt) begin
      err_d = 1'b1;
    end

    busy_d = count_d != 3'd0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q    <= '0;
      inflight_q <= '0;
      is_write_q <= '0;
      tmo_q      <= '0;
      next_src_q <= '0;
      rvalid_q   <= 1'b0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
      busy_q     <= 1'b0;
    end else begin
      count_q    <= count_d;
      inflight_q <= inflight_d;
      is_write_q <= is_write_d;
      tmo_q      <= tmo_d;
      next_src_q <= next_src_d;
      rvalid_q   <= rvalid_d;
      err_q      <= err_d;
      rdata_q    <= rdata_d;
      busy_q     <= busy_d;
    end
  end

endmodule

// File: tb/tb_tlul_rot_host_adapter.sv
module tb_tlul_rot_host_adapter;
  import tlul_pkg::*;

  localparam int MAXO = 2;
  localparam int TMO  = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  tlul_rot_host_adapter_if bus ();
  tl_h2d_t tl_h2d;
  tl_d2h_t tl_d2h;

  tlul_rot_host_adapter #(
    .MAX_OUTSTANDING(MAXO),
    .TIMEOUT_CYCLES (TMO),
    .BASE_ADDR      (32'h3b00_0000)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .core  (bus),
    .tl_o  (tl_h2d),
    .tl_i  (tl_d2h)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: per-source records plus an issue-order queue.
  bit          m_inflight [4];
  bit          m_we       [4];
  logic [31:0] m_addr     [4];
  int          m_cnt, m_next, m_age;
  int          issue_q[$];
  logic [31:0] mem [logic [31:0]];

  bit          e_rv, e_err;
  logic [31:0] e_rdata;

  logic        o_gnt, o_av, o_rv, o_err, o_busy;
  logic [2:0]  o_op;
  logic [3:0]  o_mask;
  logic [7:0]  o_src;
  logic [31:0] o_rdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_inflight[i] = 1'b0;
      m_we[i]       = 1'b0;
      m_addr[i]     = '0;
    end
    m_cnt = 0; m_next = 0; m_age = 0;
    issue_q.delete();
    e_rv = 1'b0; e_err = 1'b0; e_rdata = '0;
  endtask

  task automatic set_req(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [3:0] be);
    bus.req = 1'b1; bus.we = we; bus.addr = addr; bus.wdata = wd; bus.be = be;
  endtask

  task automatic dbeat(input int src, input logic [2:0] op, input logic [31:0] data,
                       input logic derr);
    tl_d2h.d_valid  = 1'b1;
    tl_d2h.d_source = 8'(src);
    tl_d2h.d_opcode = op;
    tl_d2h.d_data   = data;
    tl_d2h.d_error  = derr;
  endtask

  task automatic dclr();
    tl_d2h.d_valid = 1'b0;
    tl_d2h.d_error = 1'b0;
  endtask

  // One clock: check the A side against the model, apply the cycle to the model,
  // clock, then check the registered response side.
  task automatic step();
    int s, s2, cnt_pre;
    bit aligned, d_ret, tmo, ex_av, ex_gnt, exp_wr;
    logic [2:0] ex_op;
    int hits[$];
    #1;
    cnt_pre = m_cnt;
    aligned = bus.addr[1:0] == 2'b00;
    s       = int'(tl_d2h.d_source);
    d_ret   = tl_d2h.d_valid && (s < MAXO) && m_inflight[s];
    tmo     = (m_cnt > 0) && !tl_d2h.d_valid && (m_age == TMO - 1);
    ex_av   = bus.req && aligned && (m_cnt < MAXO) && !m_inflight[m_next];
    ex_gnt  = (ex_av && tl_d2h.a_ready) || (bus.req && !aligned && !d_ret && !tmo);
    o_gnt = bus.gnt; o_av = tl_h2d.a_valid; o_op = tl_h2d.a_opcode;
    o_mask = tl_h2d.a_mask; o_src = tl_h2d.a_source;
    chk("a_valid", o_av, ex_av);
    chk("gnt", o_gnt, ex_gnt);
    chk("d_ready", tl_h2d.d_ready, 1);
    if (ex_av) begin
      ex_op = !bus.we ? Get : (bus.be == 4'hF ? PutFullData : PutPartialData);
      chk("a_opcode", o_op, ex_op);
      chk("a_mask", o_mask, bus.we ? bus.be : 4'hF);
      chk("a_source", o_src, m_next);
      chk("a_address", tl_h2d.a_address, bus.addr);
      chk("a_data", tl_h2d.a_data, bus.wdata);
      chk("a_size_param", {tl_h2d.a_size, tl_h2d.a_param}, 5'b10_000);
    end
    e_rv = 1'b0; e_err = 1'b0; e_rdata = '0;
    if (d_ret) begin
      exp_wr  = m_we[s];
      e_rv    = 1'b1;
      e_err   = tl_d2h.d_error || (tl_d2h.d_opcode != (exp_wr ? AccessAck : AccessAckData));
      e_rdata = (!exp_wr && !e_err) ? tl_d2h.d_data : 32'h0;
      m_inflight[s] = 1'b0;
      m_cnt--;
      hits = issue_q.find_first_index(x) with (x == s);
      if (hits.size() > 0) issue_q.delete(hits[0]);
    end else if (tmo) begin
      s2 = issue_q.pop_front();
      m_inflight[s2] = 1'b0;
      m_cnt--;
      e_rv = 1'b1; e_err = 1'b1;
    end else if (bus.req && !aligned && ex_gnt) begin
      e_rv = 1'b1; e_err = 1'b1;
    end
    if (tl_d2h.d_valid || cnt_pre == 0 || tmo) m_age = 0;
    else m_age++;
    if (ex_av && tl_d2h.a_ready) begin
      m_inflight[m_next] = 1'b1;
      m_we[m_next]       = bus.we;
      m_addr[m_next]     = bus.addr;
      issue_q.push_back(m_next);
      m_cnt++;
      m_next = (m_next + 1) % MAXO;
      if (bus.we) begin
        if (!mem.exists(bus.addr)) mem[bus.addr] = '0;
        for (int b = 0; b < 4; b++)
          if (bus.be[b]) mem[bus.addr][8*b +: 8] = bus.wdata[8*b +: 8];
      end
    end
    @(posedge clk);
    @(negedge clk);
    o_rv = bus.rvalid; o_err = bus.err; o_rdata = bus.rdata; o_busy = bus.busy;
    chk("rvalid", o_rv, e_rv);
    if (e_rv) begin
      chk("err", o_err, e_err);
      chk("rdata", o_rdata, e_rdata);
    end
    chk("busy", o_busy, m_cnt != 0);
  endtask

  task automatic idle();
    bus.req = 1'b0;
    dclr();
    tl_d2h.a_ready = 1'b1;
  endtask

  initial begin
    int k, s;
    logic [31:0] rd;
    tl_d2h = '0;
    tl_d2h.a_ready = 1'b1;
    bus.req = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.wdata = '0; bus.be = '0;
    model_reset();
    #2 rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_gnt", bus.gnt, 0);
    chk("rst_rvalid", bus.rvalid, 0);
    chk("rst_rdata", bus.rdata, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_a_valid", tl_h2d.a_valid, 0);
    chk("rst_d_ready", tl_h2d.d_ready, 1);
    rst_n = 1'b1;
    @(negedge clk);

    // Full write, then AccessAck.
    set_req(1'b1, 32'h3b00_0000, 32'h1234_5678, 4'hF);
    step();
    chk("wr_gnt", o_gnt, 1);
    chk("wr_op", o_op, PutFullData);
    chk("wr_mask", o_mask, 4'hF);
    chk("wr_src", o_src, 0);
    idle();
    dbeat(0, AccessAck, 32'h0, 1'b0);
    step();
    dclr();
    chk("wr_rv", o_rv, 1);
    chk("wr_err", o_err, 0);
    chk("wr_rdata", o_rdata, 0);

    // Read back.
    set_req(1'b0, 32'h3b00_0000, 32'h0, 4'h0);
    step();
    chk("rd_gnt", o_gnt, 1);
    chk("rd_op", o_op, Get);
    chk("rd_busy", o_busy, 1);
    idle();
    step();
    chk("rd_busy_wait", o_busy, 1);
    dbeat(1, AccessAckData, 32'h1234_5678, 1'b0);
    step();
    dclr();
    chk("rd_rv", o_rv, 1);
    chk("rd_data", o_rdata, 32'h1234_5678);
    chk("rd_err", o_err, 0);
    chk("rd_busy_done", o_busy, 0);

    // Credit limit: third read stalls until a D beat frees source 0.
    set_req(1'b0, 32'h3b00_0010, 32'h0, 4'h0);
    step();
    chk("cr_src0", o_src, 0);
    set_req(1'b0, 32'h3b00_0014, 32'h0, 4'h0);
    step();
    chk("cr_src1", o_src, 1);
    set_req(1'b0, 32'h3b00_0018, 32'h0, 4'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("cr_stall", o_gnt, 0);
    end
    dbeat(0, AccessAckData, 32'hA5A5_0010, 1'b0);
    step();
    dclr();
    chk("cr_stall_d", o_gnt, 0);
    chk("cr_rdata0", o_rdata, 32'hA5A5_0010);
    step();
    chk("cr_regrant", o_gnt, 1);
    chk("cr_regrant_src", o_src, 0);
    idle();
    dbeat(1, AccessAckData, 32'hA5A5_0014, 1'b0);
    step();
    dbeat(0, AccessAckData, 32'hA5A5_0018, 1'b1);
    step();
    dclr();
    chk("cr_derr", o_err, 1);

    // Misaligned write: local error, no bus beat.
    set_req(1'b1, 32'h3b00_0002, 32'hFFFF_FFFF, 4'b0011);
    step();
    chk("mis_gnt", o_gnt, 1);
    chk("mis_a_valid", o_av, 0);
    chk("mis_rv", o_rv, 1);
    chk("mis_err", o_err, 1);
    chk("mis_rdata", o_rdata, 0);

    // Misaligned request colliding with a D retire is deferred one cycle.
    set_req(1'b0, 32'h3b00_0020, 32'h0, 4'h0);
    step();
    set_req(1'b0, 32'h3b00_0021, 32'h0, 4'h0);
    dbeat(1, AccessAckData, 32'h0000_0020, 1'b0);
    step();
    dclr();
    chk("mis_defer_gnt", o_gnt, 0);
    chk("mis_defer_derr", o_err, 0);
    step();
    chk("mis_late_gnt", o_gnt, 1);
    chk("mis_late_err", o_err, 1);
    idle();

    // Timeout: no D beat after a read.
    set_req(1'b0, 32'h3b00_0030, 32'h0, 4'h0);
    step();
    s = o_src;
    idle();
    k = 0;
    do begin
      step();
      k++;
    end while (!o_rv && k < 40);
    chk("tmo_latency", k, TMO);
    chk("tmo_err", o_err, 1);
    chk("tmo_rdata", o_rdata, 0);
    dbeat(s, AccessAckData, 32'hDEAD_BEEF, 1'b0);
    step();
    dclr();
    chk("tmo_late_drop", o_rv, 0);
    chk("tmo_busy", o_busy, 0);

    // Reset with two requests in flight.
    set_req(1'b0, 32'h3b00_0040, 32'h0, 4'h0);
    step();
    set_req(1'b0, 32'h3b00_0044, 32'h0, 4'h0);
    step();
    idle();
    chk("prerst_busy", o_busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", bus.busy, 0);
    chk("arst_rvalid", bus.rvalid, 0);
    chk("arst_a_valid", tl_h2d.a_valid, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    dbeat(0, AccessAckData, 32'h1111_1111, 1'b0);
    step();
    dclr();
    chk("post_rst_drop", o_rv, 0);
    set_req(1'b1, 32'h3b00_0050, 32'hCAFE_F00D, 4'hF);
    step();
    chk("post_rst_src", o_src, 0);
    chk("post_rst_gnt", o_gnt, 1);
    idle();

    // Randomized traffic against the model.
    for (int c = 0; c < 600; c++) begin
      if (bus.req && o_gnt) bus.req = 1'b0;
      if (!bus.req && $urandom_range(0, 3) != 0) begin
        bus.req   = 1'b1;
        bus.we    = 1'($urandom_range(0, 1));
        bus.addr  = 32'h3b00_0000 | (32'($urandom_range(0, 15)) << 2);
        if ($urandom_range(0, 7) == 0) bus.addr[1:0] = 2'($urandom_range(1, 3));
        bus.wdata = $urandom;
        bus.be    = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom_range(0, 15));
      end
      tl_d2h.a_ready = $urandom_range(0, 3) != 0;
      dclr();
      if (issue_q.size() > 0 && $urandom_range(0, 2) == 0) begin
        s  = issue_q[$urandom_range(0, issue_q.size() - 1)];
        rd = mem.exists(m_addr[s]) ? mem[m_addr[s]] : 32'h5A00_0000 | m_addr[s][7:0];
        dbeat(s, (m_we[s] ^ ($urandom_range(0, 7) == 0)) ? AccessAck : AccessAckData,
              m_we[s] ? 32'($urandom) : rd, $urandom_range(0, 9) == 0);
      end else if ($urandom_range(0, 19) == 0) begin
        dbeat($urandom_range(0, 7), AccessAckData, $urandom, 1'b0);
      end
      step();
    end

    // Drain.
    idle();
    k = 0;
    while (m_cnt > 0 && k < 100) begin
      s = issue_q[0];
      dbeat(s, m_we[s] ? AccessAck : AccessAckData, 32'h0F0F_0F0F, 1'b0);
      step();
      dclr();
      k++;
    end
    chk("drain_done", m_cnt, 0);
    step();
    chk("final_busy", o_busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
